// File: rtl/uart_rx_ctrl_if.sv
// UART receive front-end bus: serial line and frame configuration in,
// voted bit stream, shift strobe and frame status out.
interface uart_rx_ctrl_if #(
  parameter int PRESCALE_W = 6
);
  logic                  rx_in;
  logic [PRESCALE_W-1:0] prescale;
  logic                  par_en;
  logic                  par_typ;
  logic                  sampled_data_bit;
  logic                  deser_en;
  logic                  data_valid;
  logic                  par_err;
  logic                  stp_err;

  // Line side / configuration source.
  modport master (
    output rx_in, prescale, par_en, par_typ,
    input  sampled_data_bit, deser_en, data_valid, par_err, stp_err
  );

  // Receiver controller.
  modport slave (
    input  rx_in, prescale, par_en, par_typ,
    output sampled_data_bit, deser_en, data_valid, par_err, stp_err
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: start-bit detection, 3-sample majority voting
// around mid-bit, deserializer strobing, parity and stop-bit checking.
module uart_rx_ctrl #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic          clk,
  input  logic          rst_n,
  uart_rx_ctrl_if.slave bus
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [PRESCALE_W-1:0] ONE      = PRESCALE_W'(1);
  localparam logic [PRESCALE_W-1:0] TWO      = PRESCALE_W'(2);
  localparam logic [PRESCALE_W-1:0] MIN_P    = PRESCALE_W'(8);
  localparam logic [BIT_W-1:0]      LAST_BIT = BIT_W'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [PRESCALE_W-1:0] edge_cnt;
  logic [PRESCALE_W-1:0] p_q;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  par_en_q;
  logic                  par_typ_q;
  logic                  par_acc;
  logic                  s0;
  logic                  s1;
  logic                  sampled_q;
  logic                  deser_en_q;
  logic                  data_valid_q;
  logic                  par_err_q;
  logic                  stp_err_q;

  // Effective bit period: LSB dropped, floor of 8 so the three sample
  // points and the decision point always fit inside one bit.
  logic [PRESCALE_W-1:0] p_even;
  logic [PRESCALE_W-1:0] p_eff;
  logic [PRESCALE_W-1:0] half;
  logic [PRESCALE_W-1:0] e_s0;
  logic [PRESCALE_W-1:0] e_s1;
  logic [PRESCALE_W-1:0] e_dec;
  logic [PRESCALE_W-1:0] e_val;
  logic [PRESCALE_W-1:0] e_last;
  logic                  at_dec;
  logic                  at_last;
  logic                  vote;

  assign p_even  = {bus.prescale[PRESCALE_W-1:1], 1'b0};
  assign p_eff   = (p_even < MIN_P) ? MIN_P : p_even;
  assign half    = {1'b0, p_q[PRESCALE_W-1:1]};
  assign e_s0    = half - ONE;
  assign e_s1    = half;
  // The third sample is taken straight from the line on this edge, so the
  // registered vote becomes visible at edge half+2.
  assign e_dec   = half + ONE;
  assign e_val   = half + TWO;
  assign e_last  = p_q - ONE;
  assign at_dec  = (edge_cnt == e_dec);
  assign at_last = (edge_cnt == e_last);
  assign vote    = (s0 & s1) | (s0 & bus.rx_in) | (s1 & bus.rx_in);

  assign bus.sampled_data_bit = sampled_q;
  assign bus.deser_en         = deser_en_q;
  assign bus.data_valid       = data_valid_q;
  assign bus.par_err          = par_err_q;
  assign bus.stp_err          = stp_err_q;

  // Frame FSM with edge/bit counters, sampling and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      edge_cnt     <= '0;
      p_q          <= MIN_P;
      bit_cnt      <= '0;
      par_en_q     <= 1'b0;
      par_typ_q    <= 1'b0;
      par_acc      <= 1'b0;
      s0           <= 1'b0;
      s1           <= 1'b0;
      sampled_q    <= 1'b0;
      deser_en_q   <= 1'b0;
      data_valid_q <= 1'b0;
      par_err_q    <= 1'b0;
      stp_err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let every decision below see the
      // pre-edge values, and a later assignment in this block overrides the
      // defaults set here (pulse clears, counter increment).
      deser_en_q   <= 1'b0;
      data_valid_q <= 1'b0;

      if (state != IDLE) begin
        edge_cnt <= at_last ? '0 : edge_cnt + ONE;
        if (edge_cnt == e_s0) s0 <= bus.rx_in;
        if (edge_cnt == e_s1) s1 <= bus.rx_in;
      end

      unique case (state)
        IDLE: begin
          if (!bus.rx_in) begin
            // The detecting cycle is edge 0, so the first START cycle is edge 1.
            state     <= START;
            edge_cnt  <= ONE;
            p_q       <= p_eff;
            par_en_q  <= bus.par_en;
            par_typ_q <= bus.par_typ;
            bit_cnt   <= '0;
            par_acc   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
          end
        end

        START: begin
          if (at_dec) begin
            if (vote) begin
              state    <= IDLE;
              edge_cnt <= '0;
            end else begin
              sampled_q <= vote;
            end
          end else if (at_last) begin
            state <= DATA;
          end
        end

        DATA: begin
          if (at_dec) begin
            sampled_q  <= vote;
            deser_en_q <= 1'b1;
            par_acc    <= par_acc ^ vote;
          end
          if (at_last) begin
            if (bit_cnt == LAST_BIT) begin
              bit_cnt <= '0;
              state   <= par_en_q ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end
        end

        PARITY: begin
          if (at_dec) begin
            sampled_q <= vote;
            par_err_q <= vote != (par_acc ^ par_typ_q);
          end
          if (at_last) state <= STOP;
        end

        STOP: begin
          if (at_dec) begin
            sampled_q <= vote;
            stp_err_q <= ~vote;
          end
          // Leaving mid-stop-bit lets a start edge right after the stop bit
          // be caught without losing a cycle.
          if (edge_cnt == e_val) begin
            data_valid_q <= ~par_err_q & ~stp_err_q;
            state        <= IDLE;
            edge_cnt     <= '0;
          end
        end

        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table of frames with expected status,
// scoreboard of expected bytes checked on data_valid, plus hand-written
// glitch, reset-abort, back-to-back and break sequences.
module tb_uart_rx_ctrl;
  localparam int WIDTH = 8;
  localparam int PW    = 6;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_rx_ctrl_if #(.PRESCALE_W(PW)) bus ();

  uart_rx_ctrl #(.WIDTH(WIDTH), .PRESCALE_W(PW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Deserializer model and scoreboard.
  logic [7:0] rx_shift = '0;
  logic [7:0] sb_exp;
  logic [7:0] sb[$];
  int deser_cnt = 0;
  int dv_cnt    = 0;
  int dv_cyc    = -1;
  int deser_cyc[$];

  always @(negedge clk) begin
    if (bus.deser_en === 1'b1) begin
      rx_shift = {bus.sampled_data_bit, rx_shift[7:1]};
      deser_cnt++;
      deser_cyc.push_back(cyc);
    end
    if (bus.data_valid === 1'b1) begin
      dv_cnt++;
      dv_cyc = cyc;
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected_dv: got byte=%02h expected=no data_valid (cycle %0d)", rx_shift, cyc);
      end else begin
        sb_exp = sb.pop_front();
        check("sb_data", rx_shift, sb_exp);
      end
    end
  end

  typedef struct {
    logic [7:0]    data;
    logic [PW-1:0] pre;       // value driven on prescale
    int            p;         // bit period the line is driven with
    bit            pen;
    bit            ptyp;
    bit            par_bit;
    bit            stop_bit;
    int            noise_bit; // data bit carrying a one-cycle inversion (99 = none)
    int            noise_edge;
    bit            exp_valid;
    bit            exp_pe;
    bit            exp_se;
    int            exp_deser;
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Call at posedge+1. Returns t0 (cycle of the start edge) and the error
  // flags seen in the cycle where data_valid is due.
  task automatic send_frame(input vec_t v, output int t0, output logic snap_pe, output logic snap_se);
    logic [11:0] bits;
    int nb;
    int dv_off;
    bits    = '1;
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = v.data[i];
    if (v.pen) begin
      bits[9]  = v.par_bit;
      bits[10] = v.stop_bit;
      nb       = 11;
    end else begin
      bits[9] = v.stop_bit;
      nb      = 10;
    end
    dv_off = v.p * (nb - 1) + v.p / 2 + 3;
    if (v.exp_valid) sb.push_back(v.data);
    bus.prescale = v.pre;
    bus.par_en   = v.pen;
    bus.par_typ  = v.ptyp;
    t0      = cyc;
    snap_pe = 1'bx;
    snap_se = 1'bx;
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < v.p; c++) begin
        bus.rx_in = (b == v.noise_bit + 1 && c == v.noise_edge) ? ~bits[b] : bits[b];
        if (b * v.p + c == dv_off) begin
          @(negedge clk);
          snap_pe = bus.par_err;
          snap_se = bus.stp_err;
        end
        @(posedge clk);
        #1;
      end
    end
    bus.rx_in = 1'b1;
  endtask

  task automatic at_neg(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  int   t0;
  int   t1;
  int   base_d;
  int   base_dv;
  int   base_q;
  int   bad;
  int   exp_t;
  logic pe;
  logic se;

  initial begin
    //          data   pre    p   pen ptyp par stop noise   valid pe se deser
    vecs[0] = '{8'hA5, 6'd8,  8,  0,  0,   0,  1,   99, 0,  1,    0, 0, 8};
    vecs[1] = '{8'h3C, 6'd9,  8,  0,  0,   0,  1,   99, 0,  1,    0, 0, 8};
    vecs[2] = '{8'h96, 6'd4,  8,  0,  0,   0,  1,   99, 0,  1,    0, 0, 8};
    vecs[3] = '{8'h07, 6'd10, 10, 1,  1,   0,  1,   99, 0,  1,    0, 0, 8};
    vecs[4] = '{8'h55, 6'd32, 32, 0,  0,   0,  1,   99, 0,  1,    0, 0, 8};
    vecs[5] = '{8'hFF, 6'd8,  8,  0,  0,   0,  1,   3,  4,  1,    0, 0, 8};
    vecs[6] = '{8'h3C, 6'd8,  8,  0,  0,   0,  0,   99, 0,  0,    0, 1, 8};
    vecs[7] = '{8'h03, 6'd16, 16, 1,  0,   0,  1,   99, 0,  1,    0, 0, 8};
    vecs[8] = '{8'h03, 6'd16, 16, 1,  0,   1,  1,   99, 0,  0,    1, 0, 8};

    bus.rx_in    = 1'b1;
    bus.prescale = 6'd8;
    bus.par_en   = 1'b0;
    bus.par_typ  = 1'b0;

    #2;
    check("rst_sampled", bus.sampled_data_bit, 0);
    check("rst_deser_en", bus.deser_en, 0);
    check("rst_data_valid", bus.data_valid, 0);
    check("rst_par_err", bus.par_err, 0);
    check("rst_stp_err", bus.stp_err, 0);
    idle(2);
    rst_n = 1'b1;
    idle(5);
    check("idle_deser_cnt", deser_cnt, 0);

    // Table-driven frames.
    for (int i = 0; i < NV; i++) begin
      base_d  = deser_cnt;
      base_dv = dv_cnt;
      base_q  = deser_cyc.size();
      send_frame(vecs[i], t0, pe, se);
      idle(3);
      check($sformatf("v%0d_deser_cnt", i), deser_cnt - base_d, vecs[i].exp_deser);
      check($sformatf("v%0d_dv_cnt", i), dv_cnt - base_dv, int'(vecs[i].exp_valid));
      check($sformatf("v%0d_par_err", i), pe, vecs[i].exp_pe);
      check($sformatf("v%0d_stp_err", i), se, vecs[i].exp_se);
      if (vecs[i].exp_valid) begin
        exp_t = t0 + vecs[i].p * (WIDTH + 1 + int'(vecs[i].pen)) + vecs[i].p / 2 + 3;
        check($sformatf("v%0d_dv_cycle", i), dv_cyc, exp_t);
      end
      bad = 0;
      for (int k = 0; k < vecs[i].exp_deser; k++) begin
        exp_t = t0 + vecs[i].p * (k + 1) + vecs[i].p / 2 + 2;
        if (base_q + k >= deser_cyc.size() || deser_cyc[base_q + k] != exp_t) bad++;
      end
      check($sformatf("v%0d_deser_timing_errs", i), bad, 0);
      check($sformatf("v%0d_sb_drained", i), sb.size(), 0);
      sb.delete();
      idle(20);
    end

    // Start-bit glitch: two low cycles must be rejected.
    base_d  = deser_cnt;
    base_dv = dv_cnt;
    bus.prescale = 6'd8;
    bus.par_en   = 1'b0;
    bus.rx_in    = 1'b0;
    idle(2);
    bus.rx_in = 1'b1;
    idle(30);
    check("glitch_deser_cnt", deser_cnt - base_d, 0);
    check("glitch_dv_cnt", dv_cnt - base_dv, 0);
    check("glitch_par_err", bus.par_err, 0);
    check("glitch_stp_err", bus.stp_err, 0);

    // Reset in the middle of data bit 3 of an all-ones frame.
    base_dv   = dv_cnt;
    bus.rx_in = 1'b0;
    idle(8);
    bus.rx_in = 1'b1;
    idle(3 * 8 + 4);
    check("pre_rst_sampled", bus.sampled_data_bit, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_sampled", bus.sampled_data_bit, 0);
    check("mid_rst_deser_en", bus.deser_en, 0);
    check("mid_rst_data_valid", bus.data_valid, 0);
    check("mid_rst_par_err", bus.par_err, 0);
    check("mid_rst_stp_err", bus.stp_err, 0);
    idle(3);
    rst_n = 1'b1;
    idle(100);
    check("aborted_dv_cnt", dv_cnt - base_dv, 0);

    // Clean frame after reset, then two back-to-back frames.
    base_dv = dv_cnt;
    send_frame('{8'h5A, 6'd8, 8, 0, 0, 0, 1, 99, 0, 1, 0, 0, 8}, t0, pe, se);
    idle(3);
    check("post_rst_dv_cnt", dv_cnt - base_dv, 1);
    check("post_rst_dv_cycle", dv_cyc, t0 + 79);
    base_dv = dv_cnt;
    send_frame('{8'h00, 6'd8, 8, 0, 0, 0, 1, 99, 0, 1, 0, 0, 8}, t0, pe, se);
    send_frame('{8'hFF, 6'd8, 8, 0, 0, 0, 1, 99, 0, 1, 0, 0, 8}, t1, pe, se);
    idle(3);
    check("b2b_gap", t1 - t0, 80);
    check("b2b_dv_cnt", dv_cnt - base_dv, 2);
    check("b2b_dv_cycle", dv_cyc, t1 + 79);
    check("b2b_sb_drained", sb.size(), 0);
    sb.delete();
    idle(10);

    // Break: line low for two frame lengths; each frame ends in stp_err and
    // restarts, the final short low run is rejected as a glitch.
    base_d    = deser_cnt;
    base_dv   = dv_cnt;
    t0        = cyc;
    bus.rx_in = 1'b0;
    at_neg(t0 + 79);
    check("break1_stp_err", bus.stp_err, 1);
    at_neg(t0 + 158);
    check("break2_stp_err", bus.stp_err, 1);
    while (cyc < t0 + 160) begin
      @(posedge clk);
      #1;
    end
    bus.rx_in = 1'b1;
    idle(30);
    check("break_deser_cnt", deser_cnt - base_d, 16);
    check("break_dv_cnt", dv_cnt - base_dv, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
